// File: rtl/multi_frame_overlay.sv
// Multi-rectangle overlay sprite: NUM_RECT double-buffered rectangles (filled, outline or
// blinking outline), priority-merged through a two-stage pipeline into one RGB444 pixel.
module multi_frame_overlay #(
  parameter int NUM_RECT     = 4,
  parameter int BORDER       = 2,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [10:0]            hcount_in,
  input  logic [9:0]             vcount_in,
  input  logic [11*NUM_RECT-1:0] x_in,
  input  logic [10*NUM_RECT-1:0] y_in,
  input  logic [11*NUM_RECT-1:0] width_in,
  input  logic [10*NUM_RECT-1:0] height_in,
  input  logic [2*NUM_RECT-1:0]  mode_in,
  input  logic [12*NUM_RECT-1:0] color_in,
  input  logic                   update_in,
  output logic [11:0]            pixel_out,
  output logic                   in_sprite,
  output logic [2:0]             hit_idx
);

  localparam logic [1:0]  MODE_FILL    = 2'd1;
  localparam logic [1:0]  MODE_OUTLINE = 2'd2;
  localparam logic [1:0]  MODE_BLINK   = 2'd3;
  localparam logic [11:0] B12          = 12'(BORDER);
  localparam logic [11:0] TWO_B        = 12'(2 * BORDER);
  localparam int          CNT_W        = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [10:0] r_sh_x  [NUM_RECT];
  logic [9:0]  r_sh_y  [NUM_RECT];
  logic [10:0] r_sh_w  [NUM_RECT];
  logic [9:0]  r_sh_hg [NUM_RECT];
  logic [1:0]  r_sh_mode [NUM_RECT];
  logic [11:0] r_sh_color [NUM_RECT];
  logic [10:0] r_act_x  [NUM_RECT];
  logic [9:0]  r_act_y  [NUM_RECT];
  logic [10:0] r_act_w  [NUM_RECT];
  logic [9:0]  r_act_hg [NUM_RECT];
  logic [1:0]  r_act_mode [NUM_RECT];
  logic [11:0] r_act_color [NUM_RECT];

  logic [CNT_W-1:0]    r_frame_cnt;
  logic                r_blink_on;
  logic [NUM_RECT-1:0] r_s1_hit;
  logic [11:0]         r_s1_color [NUM_RECT];

  logic                w_frame_start;
  logic [11:0]         w_h, w_v;
  logic [NUM_RECT-1:0] w_hit;
  logic [11:0]         w_pix;
  logic [2:0]          w_idx;

  assign w_frame_start = (hcount_in == 11'd0) && (vcount_in == 10'd0);
  assign w_h           = {1'b0, hcount_in};
  assign w_v           = {2'b0, vcount_in};

  // Shadow set follows update_in; the active set only changes on frame_start, with a
  // same-cycle update bypassing the shadow so it lands in this frame.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      // NOTE: the register arrays are small config stores, not RAM, so they are reset
      // explicitly; a frame after reset must never draw stale geometry.
      for (int i = 0; i < NUM_RECT; i++) begin
        r_sh_x[i]      <= '0;
        r_sh_y[i]      <= '0;
        r_sh_w[i]      <= '0;
        r_sh_hg[i]     <= '0;
        r_sh_mode[i]   <= '0;
        r_sh_color[i]  <= '0;
        r_act_x[i]     <= '0;
        r_act_y[i]     <= '0;
        r_act_w[i]     <= '0;
        r_act_hg[i]    <= '0;
        r_act_mode[i]  <= '0;
        r_act_color[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_RECT; i++) begin
        if (update_in) begin
          r_sh_x[i]     <= x_in[11*i +: 11];
          r_sh_y[i]     <= y_in[10*i +: 10];
          r_sh_w[i]     <= width_in[11*i +: 11];
          r_sh_hg[i]    <= height_in[10*i +: 10];
          r_sh_mode[i]  <= mode_in[2*i +: 2];
          r_sh_color[i] <= color_in[12*i +: 12];
        end
        if (w_frame_start) begin
          r_act_x[i]     <= update_in ? x_in[11*i +: 11]      : r_sh_x[i];
          r_act_y[i]     <= update_in ? y_in[10*i +: 10]      : r_sh_y[i];
          r_act_w[i]     <= update_in ? width_in[11*i +: 11]  : r_sh_w[i];
          r_act_hg[i]    <= update_in ? height_in[10*i +: 10] : r_sh_hg[i];
          r_act_mode[i]  <= update_in ? mode_in[2*i +: 2]     : r_sh_mode[i];
          r_act_color[i] <= update_in ? color_in[12*i +: 12]  : r_sh_color[i];
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_frame_cnt <= '0;
      r_blink_on  <= 1'b1;
    end else if (w_frame_start) begin
      if (r_frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
        r_frame_cnt <= '0;
        r_blink_on  <= ~r_blink_on;
      end else begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  // All bounds are widened to 12 bits so x+w and y+hgt never wrap.
  for (genvar g = 0; g < NUM_RECT; g++) begin : g_hit
    logic [11:0] w_left, w_right, w_top, w_bot;
    logic        w_thin, w_outer, w_inner, w_ring;
    assign w_left  = {1'b0, r_act_x[g]};
    assign w_right = w_left + {1'b0, r_act_w[g]};
    assign w_top   = {2'b0, r_act_y[g]};
    assign w_bot   = w_top + {2'b0, r_act_hg[g]};
    assign w_thin  = ({1'b0, r_act_w[g]} <= TWO_B) || ({2'b0, r_act_hg[g]} <= TWO_B);
    assign w_outer = (w_h >= w_left) && (w_h < w_right) && (w_v >= w_top) && (w_v < w_bot);
    assign w_inner = !w_thin && (w_h >= w_left + B12) && (w_h < w_right - B12)
                     && (w_v >= w_top + B12) && (w_v < w_bot - B12);
    assign w_ring  = w_outer && !w_inner;
    assign w_hit[g] = (r_act_mode[g] == MODE_FILL)    ? w_outer :
                      (r_act_mode[g] == MODE_OUTLINE) ? w_ring  :
                      (r_act_mode[g] == MODE_BLINK)   ? (w_ring && r_blink_on) : 1'b0;
  end

  // Colours travel with the hit flags so pixel (0,0) keeps the colour of the set it was
  // tested against, even though the active set swaps on that same edge.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_s1_hit <= '0;
      for (int i = 0; i < NUM_RECT; i++) r_s1_color[i] <= '0;
    end else begin
      r_s1_hit <= w_hit;
      for (int i = 0; i < NUM_RECT; i++) r_s1_color[i] <= r_act_color[i];
    end
  end

  always_comb begin
    w_pix = '0;
    w_idx = '0;
    // NOTE: blocking assignments in a descending loop let the lowest index overwrite last,
    // and the defaults above keep this purely combinational.
    for (int i = NUM_RECT - 1; i >= 0; i--) begin
      if (r_s1_hit[i]) begin
        w_pix = r_s1_color[i];
        w_idx = 3'(i);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pixel_out <= '0;
      in_sprite <= 1'b0;
      hit_idx   <= '0;
    end else begin
      pixel_out <= w_pix;
      in_sprite <= |r_s1_hit;
      hit_idx   <= w_idx;
    end
  end

endmodule

// File: tb/tb_multi_frame_overlay.sv
// Bench for multi_frame_overlay: constant-table probes, hand sequences for swap, blink and
// reset, and randomized traffic against a frame-level reference model.
module tb_multi_frame_overlay;

  localparam int NR = 4;
  localparam int BD = 2;
  localparam int BF = 2;

  logic             clk_in = 1'b0;
  logic             rst_in = 1'b1;
  logic [10:0]      hcount_in = '0;
  logic [9:0]       vcount_in = '0;
  logic [11*NR-1:0] x_in = '0;
  logic [10*NR-1:0] y_in = '0;
  logic [11*NR-1:0] width_in = '0;
  logic [10*NR-1:0] height_in = '0;
  logic [2*NR-1:0]  mode_in = '0;
  logic [12*NR-1:0] color_in = '0;
  logic             update_in = 1'b0;
  logic [11:0]      pixel_out;
  logic             in_sprite;
  logic [2:0]       hit_idx;

  always #5 clk_in = ~clk_in;

  multi_frame_overlay #(.NUM_RECT(NR), .BORDER(BD), .BLINK_FRAMES(BF)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .x_in(x_in), .y_in(y_in), .width_in(width_in), .height_in(height_in),
    .mode_in(mode_in), .color_in(color_in), .update_in(update_in),
    .pixel_out(pixel_out), .in_sprite(in_sprite), .hit_idx(hit_idx)
  );

  typedef struct {int x; int y; int w; int ht; int mode; int color;} rect_t;
  typedef struct {rect_t r; int ph; int pv; logic [15:0] exp;} vec_t;

  rect_t       m_sh[NR];
  rect_t       m_act[NR];
  int          n_fs;
  logic [15:0] m_p1, m_out, obs;
  int          n_err = 0;
  int          n_checks = 0;
  int          cyc = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got {hit,idx,pix}=%h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] pk(input bit any, input int idx, input int pix);
    logic [2:0]  i3;
    logic [11:0] p12;
    i3  = 3'(idx);
    p12 = 12'(pix);
    return {any, i3, p12};
  endfunction

  function automatic rect_t in_rect(input int i);
    rect_t r;
    r.x     = int'(x_in[11*i +: 11]);
    r.y     = int'(y_in[10*i +: 10]);
    r.w     = int'(width_in[11*i +: 11]);
    r.ht    = int'(height_in[10*i +: 10]);
    r.mode  = int'(mode_in[2*i +: 2]);
    r.color = int'(color_in[12*i +: 12]);
    return r;
  endfunction

  // Reference: blink phase follows from the count of frame starts since reset.
  function automatic logic [15:0] model_eval(input int h, input int v);
    rect_t r;
    bit blink, outer, inner, ring, hit;
    blink = ((n_fs / BF) % 2) == 0;
    for (int i = 0; i < NR; i++) begin
      r     = m_act[i];
      outer = h >= r.x && h < r.x + r.w && v >= r.y && v < r.y + r.ht;
      inner = !(r.w <= 2*BD || r.ht <= 2*BD) && h >= r.x + BD && h < r.x + r.w - BD
              && v >= r.y + BD && v < r.y + r.ht - BD;
      ring  = outer && !inner;
      case (r.mode)
        1:       hit = outer;
        2:       hit = ring;
        3:       hit = ring && blink;
        default: hit = 1'b0;
      endcase
      if (hit) return pk(1'b1, i, r.color);
    end
    return 16'h0;
  endfunction

  task automatic step(input int h, input int v, input bit upd, input bit rst);
    logic [15:0] e;
    @(negedge clk_in);
    hcount_in = 11'(h);
    vcount_in = 10'(v);
    update_in = upd;
    rst_in    = rst;
    e = model_eval(h, v);
    if (rst) begin
      for (int i = 0; i < NR; i++) begin
        m_sh[i]  = '{0, 0, 0, 0, 0, 0};
        m_act[i] = '{0, 0, 0, 0, 0, 0};
      end
      n_fs  = 0;
      m_p1  = '0;
      m_out = '0;
    end else begin
      if (h == 0 && v == 0) begin
        for (int i = 0; i < NR; i++) m_act[i] = upd ? in_rect(i) : m_sh[i];
        n_fs++;
      end
      if (upd) for (int i = 0; i < NR; i++) m_sh[i] = in_rect(i);
      m_out = m_p1;
      m_p1  = e;
    end
    @(posedge clk_in);
    #1;
    cyc++;
    obs = {in_sprite, hit_idx, pixel_out};
    check($sformatf("model cyc%0d", cyc), obs, m_out);
  endtask

  task automatic set_rect(input int i, input int x, input int y, input int w, input int ht,
                          input int mode, input int color);
    x_in[11*i +: 11]      = 11'(x);
    y_in[10*i +: 10]      = 10'(y);
    width_in[11*i +: 11]  = 11'(w);
    height_in[10*i +: 10] = 10'(ht);
    mode_in[2*i +: 2]     = 2'(mode);
    color_in[12*i +: 12]  = 12'(color);
  endtask

  task automatic load_frame();
    step(700, 500, 1'b1, 1'b0);
    step(0, 0, 1'b0, 1'b0);
  endtask

  // After this, obs holds the pipelined result for pixel (h,v).
  task automatic probe(input int h, input int v);
    step(h, v, 1'b0, 1'b0);
    step(1500, 900, 1'b0, 1'b0);
  endtask

  vec_t tv[16];
  bit   vis[6];

  initial begin
    rect_t r1, r2, r3, r4, r5;
    r1 = '{10, 10, 20, 20, 1, 'hF00};
    r2 = '{100, 50, 40, 30, 2, 'h0AB};
    r3 = '{100, 100, 0, 10, 1, 'h555};
    r4 = '{2040, 5, 20, 10, 1, 'h123};
    r5 = '{300, 300, 3, 10, 2, 'h7E7};
    tv[0]  = '{r1, 10, 10, pk(1, 0, 'hF00)};
    tv[1]  = '{r1, 29, 29, pk(1, 0, 'hF00)};
    tv[2]  = '{r1, 30, 10, 16'h0};
    tv[3]  = '{r1, 9, 10, 16'h0};
    tv[4]  = '{r2, 101, 60, pk(1, 0, 'h0AB)};
    tv[5]  = '{r2, 102, 60, 16'h0};
    tv[6]  = '{r2, 138, 60, pk(1, 0, 'h0AB)};
    tv[7]  = '{r2, 120, 51, pk(1, 0, 'h0AB)};
    tv[8]  = '{r2, 120, 52, 16'h0};
    tv[9]  = '{r2, 120, 78, pk(1, 0, 'h0AB)};
    tv[10] = '{r3, 100, 100, 16'h0};
    tv[11] = '{r4, 2040, 5, pk(1, 0, 'h123)};
    tv[12] = '{r4, 2047, 5, pk(1, 0, 'h123)};
    tv[13] = '{r4, 0, 5, 16'h0};
    tv[14] = '{r5, 301, 305, pk(1, 0, 'h7E7)};
    tv[15] = '{r5, 302, 305, pk(1, 0, 'h7E7)};
    vis = '{1, 1, 0, 0, 1, 1};

    step(5, 5, 1'b0, 1'b1);
    check("reset outputs", obs, 16'h0);
    step(5, 5, 1'b0, 1'b0);

    for (int k = 0; k < 16; k++) begin
      set_rect(0, tv[k].r.x, tv[k].r.y, tv[k].r.w, tv[k].r.ht, tv[k].r.mode, tv[k].r.color);
      load_frame();
      probe(tv[k].ph, tv[k].pv);
      check($sformatf("vec%0d (%0d,%0d)", k, tv[k].ph, tv[k].pv), obs, tv[k].exp);
    end

    // Overlap priority
    set_rect(0, 400, 400, 50, 50, 1, 'h0F0);
    set_rect(1, 400, 400, 50, 50, 1, 'h00F);
    load_frame();
    probe(420, 420);
    check("overlap rect0 wins", obs, pk(1, 0, 'h0F0));
    set_rect(0, 400, 400, 50, 50, 0, 'h0F0);
    load_frame();
    probe(420, 420);
    check("overlap rect1 after rect0 off", obs, pk(1, 1, 'h00F));
    set_rect(1, 0, 0, 0, 0, 0, 0);

    // Mid-frame update is deferred; update on frame_start bypasses
    set_rect(0, 10, 10, 20, 20, 1, 'hF00);
    load_frame();
    set_rect(0, 200, 10, 20, 20, 1, 'hF00);
    step(50, 50, 1'b1, 1'b0);
    probe(15, 15);
    check("deferred old x still drawn", obs, pk(1, 0, 'hF00));
    probe(205, 15);
    check("deferred new x not yet", obs, 16'h0);
    step(0, 0, 1'b0, 1'b0);
    probe(205, 15);
    check("next frame new x drawn", obs, pk(1, 0, 'hF00));
    probe(15, 15);
    check("next frame old x gone", obs, 16'h0);
    set_rect(0, 10, 10, 20, 20, 1, 'hF00);
    step(0, 0, 1'b1, 1'b0);
    probe(15, 15);
    check("bypass same frame", obs, pk(1, 0, 'hF00));

    // Pixel (0,0) uses the previous set
    set_rect(0, 0, 0, 5, 5, 1, 'hF0F);
    load_frame();
    set_rect(0, 0, 0, 5, 5, 0, 'hF0F);
    step(0, 0, 1'b1, 1'b0);
    step(1, 1, 1'b0, 1'b0);
    check("pixel00 old set", obs, pk(1, 0, 'hF0F));
    step(2, 2, 1'b0, 1'b0);
    check("pixel11 new set", obs, 16'h0);

    // Blink with reset-relative frame numbering
    step(5, 5, 1'b0, 1'b1);
    set_rect(0, 500, 500, 20, 20, 3, 'h0FF);
    for (int k = 1; k < 6; k++) begin
      step(0, 0, k == 1, 1'b0);
      probe(500, 510);
      check($sformatf("blink frame%0d", k), obs, vis[k] ? pk(1, 0, 'h0FF) : 16'h0);
    end
    step(500, 510, 1'b0, 1'b0);
    step(600, 600, 1'b0, 1'b1);
    check("reset clears output", obs, 16'h0);
    step(700, 700, 1'b0, 1'b0);
    check("reset clears stage1", obs, 16'h0);
    probe(500, 510);
    check("after reset config off", obs, 16'h0);
    step(0, 0, 1'b1, 1'b0);
    probe(500, 510);
    check("after reset blink_on", obs, pk(1, 0, 'h0FF));

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int sel;
      bit upd;
      sel = int'($urandom_range(0, 999));
      upd = (sel % 40) == 0;
      if (upd)
        for (int i = 0; i < NR; i++)
          set_rect(i, int'($urandom_range(0, 300)), int'($urandom_range(0, 200)),
                   int'($urandom_range(0, 120)), int'($urandom_range(0, 100)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 4095)));
      if (sel < 2)
        step(int'($urandom_range(0, 400)), int'($urandom_range(0, 300)), 1'b0, 1'b1);
      else if (sel < 40)
        step(0, 0, upd, 1'b0);
      else
        step(int'($urandom_range(0, 400)), int'($urandom_range(0, 300)), upd, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
